audio_in_i2s_receiver: RTL and testbench

Slave-mode I2S receiver for the codec ADC path, the capture-side counterpart of the audio_out DAC transmitter. The codec drives BCLK/ADCLRCK; this block samples ADCDAT, assembles stereo left/right pairs and buffers them in a FIFO. Pairs are delivered on an Avalon-ST source to the system interconnect, typically consumed by a DMA or CPU-polled bridge. All logic runs on the fabric clock (clock_116_mhz domain).

---
 rtl/audio_in_pkg.sv | 33 +++
 rtl/audio_in_fifo.sv | 78 +++++++
 rtl/audio_in_i2s_receiver.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_audio_in_i2s_receiver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_in_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_in_pkg
//  Description : Shared types and constants for the I2S capture path
//                (receiver FSM states, channel identifiers, default width).
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_in_pkg;

    // Default bits captured per channel
    localparam int c_DEFAULT_SAMPLE_WIDTH = 16;

    // Frame-alignment / capture state machine
    typedef enum logic [1:0] {
        WAIT_ALIGN = 2'd0,
        DELAY      = 2'd1,
        SHIFT      = 2'd2,
        SKIP       = 2'd3
    } state_t;

    // Channel currently being assembled
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_t;

    // Channel that follows the given one in a stereo frame
    function automatic channel_t other_channel(input channel_t ch);
        return (ch == CH_LEFT) ? CH_RIGHT : CH_LEFT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_in_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : audio_in_fifo
//  Description : Synchronous first-word-fall-through FIFO holding stereo
//                pairs. Head word is presented on o_data whenever o_valid is
//                high; o_data reads zero while empty. A push into a full FIFO
//                is accepted only when a pop frees a slot in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_in_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_LVL_W  = c_ADDR_W + 1;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == c_LVL_W'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage array; contents need no reset because the level gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap on power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_valid = !w_empty;
    assign o_full  = w_full;
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/audio_in_i2s_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : audio_in_i2s_receiver
//  Description : Slave-mode I2S capture. Synchronises the codec BCLK/ADCLRCK/
//                ADCDAT into clk, aligns on the left-channel frame start,
//                assembles {left,right} pairs and buffers them in a FWFT FIFO
//                presented as an Avalon-ST source. Sticky overflow flags
//                pairs dropped while the FIFO is full.
//                Build option AUDIO_IN_LJ_MODE_EN adds the lj_mode input
//                selecting left-justified framing (no 1-bit delay, left =
//                LRCK high).
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_in_i2s_receiver
    import audio_in_pkg::*;
#(
    parameter int SAMPLE_WIDTH = c_DEFAULT_SAMPLE_WIDTH,
    parameter int FIFO_DEPTH   = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                            clk,
`ifdef AUDIO_IN_LJ_MODE_EN
    input  logic                            lj_mode,
`endif
    input  logic                            reset,
    input  logic                            audio_in_BCLK,
    input  logic                            audio_in_ADCLRCK,
    input  logic                            audio_in_ADCDAT,
    input  logic                            enable,
    output logic [2*SAMPLE_WIDTH-1:0]       src_data,
    output logic                            src_valid,
    input  logic                            src_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    input  logic                            overflow_clear
);

    localparam int c_CNT_W = $clog2(SAMPLE_WIDTH + 1);

    // ------------------------------------------------------------------
    // Synchronised codec signals and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lrck_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_bclk_d;
    logic                   r_lrck_bit;   // LRCK level seen at the previous BCLK rise

    logic w_bclk;
    logic w_lrck;
    logic w_dat;
    logic w_bclk_rise;
    logic w_lrck_edge;
    logic w_align;
    logic w_lj;

    // ------------------------------------------------------------------
    // Capture state
    // ------------------------------------------------------------------
    state_t                  r_state;
    channel_t                r_ch;
    logic [SAMPLE_WIDTH-1:0] r_shift;
    logic [c_CNT_W-1:0]      r_count;
    logic [SAMPLE_WIDTH-1:0] r_left_word;
    logic [SAMPLE_WIDTH-1:0] r_right_word;
    logic                    r_have_left;
    logic                    r_push;

    logic [SAMPLE_WIDTH-1:0] w_shift_next;
    logic [SAMPLE_WIDTH-1:0] w_first_shift;
    logic [SAMPLE_WIDTH-1:0] w_padded;
    logic [c_CNT_W-1:0]      w_pad_amt;
    logic [c_CNT_W-1:0]      w_count_inc;
    logic                    w_latch_en;
    logic [SAMPLE_WIDTH-1:0] w_latch_word;
    state_t                  w_begin_state;
    logic [SAMPLE_WIDTH-1:0] w_begin_shift;
    logic [c_CNT_W-1:0]      w_begin_count;

    logic w_pop;
    logic w_full;
    logic w_drop;

    // Input synchronisers plus the delayed BCLK copy for rise detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_dat_sync  <= '0;
            r_bclk_d    <= 1'b0;
            r_lrck_bit  <= 1'b0;
        end else begin
            r_bclk_sync <= (r_bclk_sync << 1) | SYNC_STAGES'(audio_in_BCLK);
            r_lrck_sync <= (r_lrck_sync << 1) | SYNC_STAGES'(audio_in_ADCLRCK);
            r_dat_sync  <= (r_dat_sync  << 1) | SYNC_STAGES'(audio_in_ADCDAT);
            r_bclk_d    <= w_bclk;
            if (w_bclk_rise) begin
                r_lrck_bit <= w_lrck;
            end
        end
    end

    assign w_bclk      = r_bclk_sync[SYNC_STAGES-1];
    assign w_lrck      = r_lrck_sync[SYNC_STAGES-1];
    assign w_dat       = r_dat_sync[SYNC_STAGES-1];
    assign w_bclk_rise = w_bclk && !r_bclk_d;
    assign w_lrck_edge = w_bclk_rise && (w_lrck != r_lrck_bit);

`ifdef AUDIO_IN_LJ_MODE_EN
    logic r_lj;

    // Frame format is frozen once alignment leaves WAIT_ALIGN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lj <= 1'b0;
        end else if (r_state == WAIT_ALIGN) begin
            r_lj <= lj_mode;
        end
    end

    assign w_lj = (r_state == WAIT_ALIGN) ? lj_mode : r_lj;
`else
    assign w_lj = 1'b0;
`endif

    // Left channel starts on LRCK falling (I2S) or rising (left-justified)
    assign w_align = w_bclk_rise &&
                     (w_lj ? (!r_lrck_bit && w_lrck) : (r_lrck_bit && !w_lrck));

    // Per-rise datapath values and the word-latch decision
    always_comb begin
        w_shift_next  = {r_shift[SAMPLE_WIDTH-2:0], w_dat};
        w_first_shift = {{(SAMPLE_WIDTH-1){1'b0}}, w_dat};
        w_pad_amt     = c_CNT_W'(SAMPLE_WIDTH) - r_count;
        w_padded      = r_shift << w_pad_amt;
        w_count_inc   = r_count + 1'b1;
        w_latch_en    = 1'b0;
        w_latch_word  = '0;
        // I2S: the LRCK-transition rise is the delay slot, MSB follows.
        // Left-justified: the transition rise already carries the MSB.
        if (w_lj) begin
            w_begin_state = SHIFT;
            w_begin_shift = w_first_shift;
            w_begin_count = c_CNT_W'(1);
        end else begin
            w_begin_state = DELAY;
            w_begin_shift = '0;
            w_begin_count = '0;
        end
        if (enable && w_bclk_rise) begin
            case (r_state)
                DELAY: begin
                    if (w_lrck_edge) begin
                        w_latch_en   = 1'b1;
                        w_latch_word = '0;
                    end
                end
                SHIFT: begin
                    if (w_lrck_edge) begin
                        w_latch_en   = 1'b1;
                        w_latch_word = w_padded;
                    end else if (w_count_inc == c_CNT_W'(SAMPLE_WIDTH)) begin
                        w_latch_en   = 1'b1;
                        w_latch_word = w_shift_next;
                    end
                end
                default: begin
                    w_latch_en = 1'b0;
                end
            endcase
        end
    end

    // Capture FSM: alignment, bit shifting, word latching and push request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= WAIT_ALIGN;
            r_ch         <= CH_LEFT;
            r_shift      <= '0;
            r_count      <= '0;
            r_left_word  <= '0;
            r_right_word <= '0;
            r_have_left  <= 1'b0;
            r_push       <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (!enable) begin
                r_state     <= WAIT_ALIGN;
                r_shift     <= '0;
                r_count     <= '0;
                r_have_left <= 1'b0;
            end else if (w_bclk_rise) begin
                case (r_state)
                    WAIT_ALIGN: begin
                        if (w_align) begin
                            r_ch        <= CH_LEFT;
                            r_have_left <= 1'b0;
                            r_state     <= w_begin_state;
                            r_shift     <= w_begin_shift;
                            r_count     <= w_begin_count;
                        end
                    end
                    DELAY: begin
                        if (w_lrck_edge) begin
                            r_ch    <= other_channel(r_ch);
                            r_state <= w_begin_state;
                            r_shift <= w_begin_shift;
                            r_count <= w_begin_count;
                        end else begin
                            r_state <= SHIFT;
                            r_shift <= w_first_shift;
                            r_count <= c_CNT_W'(1);
                        end
                    end
                    SHIFT: begin
                        if (w_lrck_edge) begin
                            r_ch    <= other_channel(r_ch);
                            r_state <= w_begin_state;
                            r_shift <= w_begin_shift;
                            r_count <= w_begin_count;
                        end else begin
                            r_shift <= w_shift_next;
                            r_count <= w_count_inc;
                            if (w_count_inc == c_CNT_W'(SAMPLE_WIDTH)) begin
                                r_state <= SKIP;
                            end
                        end
                    end
                    default: begin
                        if (w_lrck_edge) begin
                            r_ch    <= other_channel(r_ch);
                            r_state <= w_begin_state;
                            r_shift <= w_begin_shift;
                            r_count <= w_begin_count;
                        end
                    end
                endcase
            end
            // A right word only forms a pair if its left partner was captured
            if (w_latch_en) begin
                if (r_ch == CH_LEFT) begin
                    r_left_word <= w_latch_word;
                    r_have_left <= 1'b1;
                end else begin
                    r_right_word <= w_latch_word;
                    r_have_left  <= 1'b0;
                    r_push       <= r_have_left;
                end
            end
        end
    end

    assign w_pop  = src_valid && src_ready;
    assign w_drop = r_push && w_full && !w_pop;

    // Sticky overflow; a new drop outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (w_drop) begin
            overflow <= 1'b1;
        end else if (overflow_clear) begin
            overflow <= 1'b0;
        end
    end

    audio_in_fifo #(
        .WIDTH (2*SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (r_push),
        .i_data  ({r_left_word, r_right_word}),
        .i_pop   (w_pop),
        .o_data  (src_data),
        .o_valid (src_valid),
        .o_full  (w_full),
        .o_level (fifo_level)
    );

endmodule
`default_nettype wire

// File: tb/tb_audio_in_i2s_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_in_i2s_receiver
//  Description : Directed self-checking bench for audio_in_i2s_receiver.
//                A codec model drives BCLK = clk/16 with 32-bit slots; popped
//                pairs are collected by a monitor and compared against
//                hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_in_i2s_receiver;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bclk = 1'b0;
    logic        lrck = 1'b1;
    logic        dat = 1'b0;
    logic        enable = 1'b0;
    logic        src_ready = 1'b0;
    logic        overflow_clear = 1'b0;
    logic [31:0] src_data;
    logic        src_valid;
    logic [4:0]  fifo_level;
    logic        overflow;
`ifdef AUDIO_IN_LJ_MODE_EN
    logic        lj_mode = 1'b0;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          bitrise_cyc = 0;
    int          valid_rise_cyc = -1;
    logic        prev_valid = 1'b0;
    logic [31:0] got_q[$];

    audio_in_i2s_receiver #(
        .SAMPLE_WIDTH (16),
        .FIFO_DEPTH   (16),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk              (clk),
`ifdef AUDIO_IN_LJ_MODE_EN
        .lj_mode          (lj_mode),
`endif
        .reset            (reset),
        .audio_in_BCLK    (bclk),
        .audio_in_ADCLRCK (lrck),
        .audio_in_ADCDAT  (dat),
        .enable           (enable),
        .src_data         (src_data),
        .src_valid        (src_valid),
        .src_ready        (src_ready),
        .fifo_level       (fifo_level),
        .overflow         (overflow),
        .overflow_clear   (overflow_clear)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every accepted pair and the cycle of each src_valid rise
    always @(negedge clk) begin
        if (src_valid && src_ready) got_q.push_back(src_data);
        if (src_valid && !prev_valid) valid_rise_cyc <= cyc;
        prev_valid <= src_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 src_ready = v;
    endtask

    // One bit period: 8 clk low then 8 clk high; LRCK/DAT change with BCLK fall
    task automatic send_bit(input logic lr, input logic d, input bit mark);
        @(negedge clk);
        bclk = 1'b0;
        lrck = lr;
        dat  = d;
        repeat (8) @(negedge clk);
        bclk = 1'b1;
        if (mark) bitrise_cyc = cyc;
        repeat (7) @(negedge clk);
    endtask

    // Slot of nbits; word starts after dly bits, zeros elsewhere
    task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits,
                             input int dly, input bit mark);
        for (int i = 0; i < nbits; i++) begin
            int   idx;
            logic b;
            idx = i - dly;
            b   = (idx >= 0 && idx < 16) ? w[15-idx] : 1'b0;
            send_bit(lr, b, mark && (idx == 15));
        end
    endtask

    task automatic send_i2s_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, 32, 1, 1'b0);
        send_slot(1'b1, r, 32, 1, 1'b1);
    endtask

    initial begin
        int nbad;
        logic [31:0] head;

        // Reset state
        wait_clks(3);
        reset = 1'b0;
        wait_clks(1);
        chk("reset_valid", {31'd0, src_valid}, 32'd0);
        chk("reset_data", src_data, 32'd0);
        chk("reset_level", {27'd0, fifo_level}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);

        // Basic pair and latency
        enable = 1'b1;
        set_ready(1'b1);
        got_q.delete();
        send_slot(1'b1, 16'h0000, 8, 1, 1'b0);
        send_i2s_frame(16'hA5C3, 16'h1234);
        wait_clks(10);
        chk("pair1_count", 32'(got_q.size()), 32'd1);
        head = (got_q.size() > 0) ? got_q[0] : 32'hXXXX_XXXX;
        chk("pair1_data", head, 32'hA5C3_1234);
        chk("pair1_latency",
            {31'd0, (valid_rise_cyc >= bitrise_cyc) && (valid_rise_cyc - bitrise_cyc <= SYNC + 4)},
            32'd1);

        // Second pattern in the continuous stream
        got_q.delete();
        send_i2s_frame(16'h0F0F, 16'hF0F0);
        wait_clks(10);
        chk("pair2_count", 32'(got_q.size()), 32'd1);
        head = (got_q.size() > 0) ? got_q[0] : 32'hXXXX_XXXX;
        chk("pair2_data", head, 32'h0F0F_F0F0);

        // Enable raised in the middle of the right channel
        enable = 1'b0;
        got_q.delete();
        send_slot(1'b0, 16'h1111, 32, 1, 1'b0);
        send_slot(1'b1, 16'h2222, 10, 1, 1'b0);
        enable = 1'b1;
        send_slot(1'b1, 16'h0000, 22, 1, 1'b0);
        send_i2s_frame(16'h3333, 16'h4444);
        wait_clks(10);
        chk("late_enable_count", 32'(got_q.size()), 32'd1);
        head = (got_q.size() > 0) ? got_q[0] : 32'hXXXX_XXXX;
        chk("late_enable_data", head, 32'h3333_4444);

        // Overflow: 17 pairs into a 16-deep FIFO with the sink stalled
        set_ready(1'b0);
        got_q.delete();
        for (int i = 0; i < 17; i++) begin
            send_i2s_frame(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        end
        wait_clks(10);
        chk("full_level", {27'd0, fifo_level}, 32'd16);
        chk("overflow_set", {31'd0, overflow}, 32'd1);
        set_ready(1'b1);
        for (int i = 0; i < 64 && src_valid; i++) @(negedge clk);
        chk("drain_done", {31'd0, src_valid}, 32'd0);
        chk("drain_count", 32'(got_q.size()), 32'd16);
        nbad = 0;
        for (int i = 0; i < got_q.size() && i < 16; i++) begin
            if (got_q[i] !== {16'h1000 + 16'(i), 16'h2000 + 16'(i)}) nbad++;
        end
        chk("drain_bad_pairs", 32'(nbad), 32'd0);
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);
        @(negedge clk) overflow_clear = 1'b1;
        @(negedge clk) overflow_clear = 1'b0;
        chk("overflow_cleared", {31'd0, overflow}, 32'd0);

        // Short left frame: 12 bits of ones before LRCK flips
        got_q.delete();
        send_slot(1'b0, 16'hFFFF, 13, 1, 1'b0);
        send_slot(1'b1, 16'h1234, 32, 1, 1'b1);
        wait_clks(10);
        chk("short_count", 32'(got_q.size()), 32'd1);
        head = (got_q.size() > 0) ? got_q[0] : 32'hXXXX_XXXX;
        chk("short_data", head, 32'hFFF0_1234);

        // Reset mid-SHIFT with three pairs buffered
        set_ready(1'b0);
        got_q.delete();
        send_i2s_frame(16'hA001, 16'hB001);
        send_i2s_frame(16'hA002, 16'hB002);
        send_i2s_frame(16'hA003, 16'hB003);
        wait_clks(4);
        chk("pre_reset_level", {27'd0, fifo_level}, 32'd3);
        send_slot(1'b0, 16'hBEEF, 8, 1, 1'b0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_valid", {31'd0, src_valid}, 32'd0);
        chk("mid_reset_level", {27'd0, fifo_level}, 32'd0);
        chk("mid_reset_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        set_ready(1'b1);
        send_slot(1'b0, 16'hBEEF, 24, 1, 1'b0);
        send_slot(1'b1, 16'h0000, 32, 1, 1'b0);
        send_i2s_frame(16'h5A5A, 16'hC3C3);
        wait_clks(10);
        chk("post_reset_count", 32'(got_q.size()), 32'd1);
        head = (got_q.size() > 0) ? got_q[0] : 32'hXXXX_XXXX;
        chk("post_reset_data", head, 32'h5A5A_C3C3);

`ifdef AUDIO_IN_LJ_MODE_EN
        // Left-justified stream: left while LRCK high, MSB on the first rise
        enable  = 1'b0;
        lj_mode = 1'b1;
        wait_clks(2);
        enable  = 1'b1;
        got_q.delete();
        send_slot(1'b0, 16'h0000, 8, 0, 1'b0);
        send_slot(1'b1, 16'h8001, 32, 0, 1'b0);
        send_slot(1'b0, 16'h7FFE, 32, 0, 1'b0);
        wait_clks(10);
        chk("lj_count", 32'(got_q.size()), 32'd1);
        head = (got_q.size() > 0) ? got_q[0] : 32'hXXXX_XXXX;
        chk("lj_data", head, 32'h8001_7FFE);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
